weight_load_ctrl: RTL and testbench

- Sequences the per-column weight FIFOs that feed the MMU.
- FILL phase: accepts a weight tile from the DDR-side byte stream and steers each byte to the push of the correct column FIFO.
- LOAD phase: once the MMU grants, issues column-skewed pops and drives en_load_weight so the MMU latches one full tile.
- Sits between the DDR controller and the N_COLS weight FIFOs / MMU weight-load port.

---
 rtl/tpu_pkg.sv | 21 ++
 rtl/weight_load_ctrl_if.sv | 29 ++
 rtl/weight_load_ctrl_skew.sv | 21 ++
 rtl/weight_load_ctrl.sv | 137 +++++++++++++
 tb/tb_weight_load_ctrl.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/tpu_pkg.sv
// Shared types and helpers for the TPU weight/activation sequencing blocks.
package tpu_pkg;

  localparam int WEIGHT_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    FILL,
    WAIT,
    LOAD,
    DRAIN,
    DONE
  } wl_state_t;

  // Bits needed to hold 0..max_val; never returns zero so 1-deep counters stay legal.
  function automatic int cnt_w(input int max_val);
    cnt_w = (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/weight_load_ctrl_if.sv
// DDR byte stream, column FIFO and MMU weight-load signals of weight_load_ctrl.
interface weight_load_ctrl_if
  import tpu_pkg::*;
#(
  parameter int N_COLS = 2
) ();
  logic                start;
  logic                busy;
  logic                done;
  logic                ddr_valid;
  logic [WEIGHT_W-1:0] ddr_data;
  logic                ddr_ready;
  logic                fifo_clr;
  logic [N_COLS-1:0]   fifo_push;
  logic [WEIGHT_W-1:0] fifo_data;
  logic [N_COLS-1:0]   fifo_pop;
  logic                mmu_grant;
  logic                en_load_weight;

  modport master (
    input  start, ddr_valid, ddr_data, mmu_grant,
    output busy, done, ddr_ready, fifo_clr, fifo_push, fifo_data, fifo_pop, en_load_weight
  );

  modport slave (
    output start, ddr_valid, ddr_data, mmu_grant,
    input  busy, done, ddr_ready, fifo_clr, fifo_push, fifo_data, fifo_pop, en_load_weight
  );
endinterface

// File: rtl/weight_load_ctrl_skew.sv
// Diagonal pop generator: column c pops while c <= t <= c+N_ROWS-1.
module skew_pop_gen #(
  parameter int N_ROWS = 2,
  parameter int N_COLS = 2,
  parameter int T_W    = 2
) (
  input  logic [T_W-1:0]    t,
  input  logic              active,
  output logic [N_COLS-1:0] pop,
  output logic              in_window
);
  localparam int T_LAST = N_ROWS + N_COLS - 2;

  assign in_window = active && (int'(t) <= T_LAST);

  generate
    for (genvar gi = 0; gi < N_COLS; gi++) begin : g_col
      assign pop[gi] = active && (int'(t) >= gi) && (int'(t) <= gi + N_ROWS - 1);
    end
  endgenerate
endmodule

// File: rtl/weight_load_ctrl.sv
// Fills the per-column weight FIFOs from the DDR byte stream, then pops them
// with a column skew so the MMU latches one full weight tile.
module weight_load_ctrl
  import tpu_pkg::*;
#(
  parameter int N_ROWS     = 2,
  parameter int N_COLS     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  weight_load_ctrl_if.master bus
);
  localparam int ROW_W  = cnt_w(N_ROWS - 1);
  localparam int COL_W  = cnt_w(N_COLS - 1);
  localparam int T_LAST = N_ROWS + N_COLS - 2;
  localparam int T_W    = cnt_w(T_LAST);

  generate
    if (N_ROWS > FIFO_DEPTH) begin : g_depth_chk
      $error("weight_load_ctrl: N_ROWS must not exceed FIFO_DEPTH");
    end
  endgenerate

  wl_state_t            state_reg, state_next;
  logic [ROW_W-1:0]     row_cnt_reg, row_cnt_next;
  logic [COL_W-1:0]     col_cnt_reg, col_cnt_next;
  logic [T_W-1:0]       t_reg, t_next;
  logic                 en_load_reg;

  logic                 busy_c, done_c, ready_c, clr_c, push_en, load_active;
  logic [WEIGHT_W-1:0]  data_c;
  logic                 in_window;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      row_cnt_reg <= '0;
      col_cnt_reg <= '0;
      t_reg       <= '0;
      en_load_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      row_cnt_reg <= row_cnt_next;
      col_cnt_reg <= col_cnt_next;
      t_reg       <= t_next;
      en_load_reg <= in_window;
    end
  end

  always_comb begin
    state_next   = state_reg;
    row_cnt_next = row_cnt_reg;
    col_cnt_next = col_cnt_reg;
    t_next       = t_reg;
    busy_c       = (state_reg != IDLE) && (state_reg != DONE);
    done_c       = 1'b0;
    ready_c      = 1'b0;
    clr_c        = 1'b0;
    push_en      = 1'b0;
    data_c       = '0;
    load_active  = 1'b0;
    case (state_reg)
      IDLE: if (bus.start) state_next = CLR;
      CLR: begin
        clr_c        = 1'b1;
        row_cnt_next = '0;
        col_cnt_next = '0;
        state_next   = FILL;
      end
      FILL: begin
        ready_c = 1'b1;
        if (bus.ddr_valid) begin
          push_en = 1'b1;
          data_c  = bus.ddr_data;
          if (row_cnt_reg == ROW_W'(N_ROWS - 1)) begin
            row_cnt_next = '0;
            if (col_cnt_reg == COL_W'(N_COLS - 1)) begin
              col_cnt_next = '0;
              state_next   = WAIT;
            end else begin
              col_cnt_next = col_cnt_reg + COL_W'(1);
            end
          end else begin
            row_cnt_next = row_cnt_reg + ROW_W'(1);
          end
        end
      end
      WAIT: begin
        if (bus.mmu_grant) begin
          t_next     = '0;
          state_next = LOAD;
        end
      end
      LOAD: begin
        load_active = 1'b1;
        if (t_reg == T_W'(T_LAST)) begin
          t_next     = '0;
          state_next = DRAIN;
        end else begin
          t_next = t_reg + T_W'(1);
        end
      end
      DRAIN: state_next = DONE;
      DONE: begin
        done_c     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Data is shared by all columns; only the addressed column sees a push.
  generate
    for (genvar gi = 0; gi < N_COLS; gi++) begin : g_push
      assign bus.fifo_push[gi] = push_en && (col_cnt_reg == COL_W'(gi));
    end
  endgenerate

  skew_pop_gen #(
    .N_ROWS (N_ROWS),
    .N_COLS (N_COLS),
    .T_W    (T_W)
  ) u_skew (
    .t         (t_reg),
    .active    (load_active),
    .pop       (bus.fifo_pop),
    .in_window (in_window)
  );

  assign bus.busy           = busy_c;
  assign bus.done           = done_c;
  assign bus.ddr_ready      = ready_c;
  assign bus.fifo_clr       = clr_c;
  assign bus.fifo_data      = data_c;
  assign bus.en_load_weight = en_load_reg;
endmodule

// File: tb/tb_weight_load_ctrl.sv
// Scoreboard bench for weight_load_ctrl: a 2x2 instance and a 4x3 instance.
module tb_weight_load_ctrl;
  import tpu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst_n_v, start_v, valid_v, grant_v;
  logic [7:0] data_v [2];

  logic [1:0] busy_o, done_o, ready_o, clr_o, en_o;
  logic [2:0] push_o [2];
  logic [2:0] pop_o  [2];
  logic [7:0] fdata_o [2];

  weight_load_ctrl_if #(.N_COLS(2)) bus0 ();
  weight_load_ctrl_if #(.N_COLS(3)) bus1 ();

  weight_load_ctrl #(.N_ROWS(2), .N_COLS(2), .FIFO_DEPTH(4)) dut0 (
    .clk(clk), .rst_n(rst_n_v[0]), .bus(bus0.master));
  weight_load_ctrl #(.N_ROWS(4), .N_COLS(3), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .rst_n(rst_n_v[1]), .bus(bus1.master));

  assign bus0.start = start_v[0];  assign bus1.start = start_v[1];
  assign bus0.ddr_valid = valid_v[0]; assign bus1.ddr_valid = valid_v[1];
  assign bus0.ddr_data = data_v[0]; assign bus1.ddr_data = data_v[1];
  assign bus0.mmu_grant = grant_v[0]; assign bus1.mmu_grant = grant_v[1];

  assign busy_o[0] = bus0.busy;   assign busy_o[1] = bus1.busy;
  assign done_o[0] = bus0.done;   assign done_o[1] = bus1.done;
  assign ready_o[0] = bus0.ddr_ready; assign ready_o[1] = bus1.ddr_ready;
  assign clr_o[0] = bus0.fifo_clr; assign clr_o[1] = bus1.fifo_clr;
  assign en_o[0] = bus0.en_load_weight; assign en_o[1] = bus1.en_load_weight;
  assign push_o[0] = {1'b0, bus0.fifo_push}; assign push_o[1] = bus1.fifo_push;
  assign pop_o[0] = {1'b0, bus0.fifo_pop};   assign pop_o[1] = bus1.fifo_pop;
  assign fdata_o[0] = bus0.fifo_data; assign fdata_o[1] = bus1.fifo_data;

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard queues (per instance) and a model of the column FIFOs (index i*3+c).
  logic [31:0] exp_push_q [2][$];
  logic [31:0] exp_pop_q  [2][$];
  logic [31:0] exp_mmu_q  [2][$];
  logic [31:0] exp_mask_q [2][$];
  logic [7:0]  fq [6][$];
  logic [7:0]  dout [6];
  int done_cnt [2];
  int clr_cnt  [2];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    for (int k = 0; k < 6; k++) dout[k] = 8'h00;
    for (int k = 0; k < 2; k++) begin done_cnt[k] = 0; clr_cnt[k] = 0; end
  end

  // Monitor: registered FIFO output means en_load_weight checks the previous cycle's pops.
  always @(negedge clk) begin
    logic [31:0] w, m, obs, e;
    for (int i = 0; i < 2; i++) begin
      if (rst_n_v[i]) begin
        if (en_o[i]) begin
          if (exp_mmu_q[i].size() == 0) check_val("mmu_unexpected_en", 32'd1, 32'd0);
          else begin
            w = exp_mmu_q[i].pop_front();
            m = exp_mask_q[i].pop_front();
            obs = {8'h00, dout[i*3+2], dout[i*3+1], dout[i*3]} & m;
            check_val("mmu_word", obs, w);
          end
        end
        if (push_o[i] != 3'b000 && pop_o[i] != 3'b000)
          check_val("push_pop_excl", {29'd0, pop_o[i]}, 32'd0);
        if (push_o[i] != 3'b000) begin
          if (exp_push_q[i].size() == 0) check_val("push_unexpected", {21'd0, push_o[i], fdata_o[i]}, 32'd0);
          else begin
            e = exp_push_q[i].pop_front();
            check_val("push", {21'd0, push_o[i], fdata_o[i]}, e);
          end
          for (int c = 0; c < 3; c++) if (push_o[i][c]) fq[i*3+c].push_back(fdata_o[i]);
        end
        if (pop_o[i] != 3'b000) begin
          if (exp_pop_q[i].size() == 0) check_val("pop_unexpected", {29'd0, pop_o[i]}, 32'd0);
          else begin
            e = exp_pop_q[i].pop_front();
            check_val("pop_vec", {29'd0, pop_o[i]}, e);
          end
          for (int c = 0; c < 3; c++) if (pop_o[i][c]) begin
            if (fq[i*3+c].size() == 0) check_val("fifo_underflow", 32'd1, 32'd0);
            else dout[i*3+c] = fq[i*3+c].pop_front();
          end
        end
        if (clr_o[i]) begin
          clr_cnt[i]++;
          for (int c = 0; c < 3; c++) fq[i*3+c].delete();
        end
        if (done_o[i]) done_cnt[i]++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input int i, input string tag);
    check_val({tag, "_busy"}, {31'd0, busy_o[i]}, 32'd0);
    check_val({tag, "_done"}, {31'd0, done_o[i]}, 32'd0);
    check_val({tag, "_ready"}, {31'd0, ready_o[i]}, 32'd0);
    check_val({tag, "_clr"}, {31'd0, clr_o[i]}, 32'd0);
    check_val({tag, "_push"}, {29'd0, push_o[i]}, 32'd0);
    check_val({tag, "_pop"}, {29'd0, pop_o[i]}, 32'd0);
    check_val({tag, "_en"}, {31'd0, en_o[i]}, 32'd0);
    check_val({tag, "_data"}, {24'd0, fdata_o[i]}, 32'd0);
  endtask

  task automatic run_tile(input int i, input int nr, input int nc,
                          input logic [7:0] first, input logic [7:0] step,
                          input bit gaps, input int grant_dly,
                          input bit start_glitch, input bit abort);
    int nb, d0, c0, cyc;
    logic rdy;
    logic [7:0] bv;
    logic [31:0] pv, m, w;
    nb = nr * nc;
    d0 = done_cnt[i];
    c0 = clr_cnt[i];
    for (int k = 0; k < nb; k++) begin
      bv = first + 8'(int'(step) * k);
      exp_push_q[i].push_back(((32'd1 << (k / nr)) << 8) | {24'd0, bv});
    end
    for (int t = 0; t <= nr + nc - 2; t++) begin
      pv = 0; m = 0; w = 0;
      for (int c = 0; c < nc; c++) begin
        if (t >= c && t <= c + nr - 1) begin
          bv = first + 8'(int'(step) * (c * nr + t - c));
          pv = pv | (32'd1 << c);
          m  = m | (32'hFF << (8 * c));
          w  = w | ({24'd0, bv} << (8 * c));
        end
      end
      exp_pop_q[i].push_back(pv);
      exp_mask_q[i].push_back(m);
      exp_mmu_q[i].push_back(w);
    end

    start_v[i] = 1'b1;
    tick();
    start_v[i] = 1'b0;
    check_val("clr_pulse", {31'd0, clr_o[i]}, 32'd1);
    check_val("clr_no_ready", {31'd0, ready_o[i]}, 32'd0);
    tick();

    for (int k = 0; k < nb; k++) begin
      if (gaps && k > 0) begin
        valid_v[i] = 1'b0;
        tick();
        tick();
      end
      valid_v[i] = 1'b1;
      data_v[i]  = first + 8'(int'(step) * k);
      if (start_glitch && k == 1) start_v[i] = 1'b1;
      cyc = 0;
      do begin
        rdy = ready_o[i];
        tick();
        start_v[i] = 1'b0;
        cyc++;
      end while (!rdy && cyc < 20);
      if (!rdy) check_val("ready_timeout", 32'd0, 32'd1);
    end
    valid_v[i] = 1'b0;
    check_val("ready_drop", {31'd0, ready_o[i]}, 32'd0);
    check_val("busy_wait", {31'd0, busy_o[i]}, 32'd1);

    repeat (grant_dly) begin
      check_val("wait_busy", {31'd0, busy_o[i]}, 32'd1);
      check_val("wait_ready", {31'd0, ready_o[i]}, 32'd0);
      check_val("wait_pop", {29'd0, pop_o[i]}, 32'd0);
      tick();
    end

    grant_v[i] = 1'b1;
    tick();
    grant_v[i] = 1'b0;
    check_val("first_pop", {29'd0, pop_o[i]}, 32'd1);

    if (abort) begin
      tick();
      rst_n_v[i] = 1'b0;
      #1;
      check_idle_outputs(i, "abort");
      exp_push_q[i].delete(); exp_pop_q[i].delete();
      exp_mmu_q[i].delete();  exp_mask_q[i].delete();
      for (int c = 0; c < 3; c++) begin fq[i*3+c].delete(); dout[i*3+c] = 8'h00; end
      tick();
      rst_n_v[i] = 1'b1;
      tick();
      return;
    end

    cyc = 0;
    while (!done_o[i] && cyc < 40) begin
      tick();
      cyc++;
    end
    check_val("done_seen", {31'd0, done_o[i]}, 32'd1);
    check_val("done_busy", {31'd0, busy_o[i]}, 32'd0);
    if (start_glitch) start_v[i] = 1'b1;
    tick();
    start_v[i] = 1'b0;
    check_val("idle_after_done", {31'd0, busy_o[i]}, 32'd0);
    tick();
    check_val("no_restart", {31'd0, busy_o[i] | clr_o[i]}, 32'd0);

    check_val("done_count", done_cnt[i] - d0, 32'd1);
    check_val("clr_count", clr_cnt[i] - c0, 32'd1);
    check_val("push_left", exp_push_q[i].size(), 32'd0);
    check_val("pop_left", exp_pop_q[i].size(), 32'd0);
    check_val("mmu_left", exp_mmu_q[i].size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n_v = 2'b00; start_v = 2'b00; valid_v = 2'b00; grant_v = 2'b00;
    data_v[0] = 8'h00; data_v[1] = 8'h00;
    tick();
    tick();
    check_idle_outputs(0, "reset0");
    check_idle_outputs(1, "reset1");
    rst_n_v = 2'b11;
    tick();

    run_tile(0, 2, 2, 8'h11, 8'h11, 1'b0, 0,  1'b0, 1'b0);
    run_tile(0, 2, 2, 8'h11, 8'h11, 1'b1, 0,  1'b0, 1'b0);
    run_tile(0, 2, 2, 8'h11, 8'h11, 1'b0, 10, 1'b0, 1'b0);
    run_tile(0, 2, 2, 8'h11, 8'h11, 1'b0, 0,  1'b0, 1'b1);
    run_tile(0, 2, 2, 8'hA1, 8'h01, 1'b0, 0,  1'b0, 1'b0);
    run_tile(0, 2, 2, 8'h11, 8'h11, 1'b0, 0,  1'b1, 1'b0);
    run_tile(1, 4, 3, 8'h01, 8'h01, 1'b0, 2,  1'b0, 1'b0);
    run_tile(1, 4, 3, 8'h01, 8'h01, 1'b1, 0,  1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
